// File: rtl/controle_varredura_2de5.sv
// Scan controller for an N-digit 2-of-5 display.
// One shared decoder is time-multiplexed across the digits, with a dark gap between them.
module controle_varredura_2de5 #(
  parameter int N_DIG = 4,
  parameter int DIV   = 1000,
  parameter int DEAD  = 2,
  localparam int AW   = (N_DIG > 1) ? $clog2(N_DIG) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [4:0]       wr_data,
  output logic [4:0]       codigo,
  output logic [N_DIG-1:0] anodo,
  output logic             apaga,
  output logic [N_DIG-1:0] erro_dig,
  output logic             quadro
);

  localparam int CMAX = (DIV > DEAD) ? DIV : DEAD;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] DIV_L  = CW'(DIV - 1);
  localparam logic [CW-1:0] DEAD_L = CW'(DEAD - 1);
  localparam logic [AW-1:0] LAST   = AW'(N_DIG - 1);
  localparam logic [AW:0]   NLIM   = (AW + 1)'(N_DIG);

  typedef enum logic [1:0] {
    OFF,
    GUARD,
    SHOW
  } st_t;

  st_t             state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [AW-1:0]   dig, dig_n, nxt;
  logic [4:0]      codigo_n;
  logic [N_DIG-1:0] anodo_n;
  logic            apaga_n;
  logic            quadro_n;

  logic [4:0]      bank [N_DIG];
  logic            addr_ok;
  logic            bad;

  assign addr_ok = {1'b0, wr_addr} < NLIM;
  assign bad     = $countones(wr_data) != 2;
  assign nxt     = (dig == LAST) ? '0 : dig + AW'(1);

  // Digit register bank and its per-digit validity flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_DIG; i++) bank[i] <= '0;
      erro_dig <= '1;
    end else if (wr_en && addr_ok) begin
      bank[wr_addr]     <= wr_data;
      erro_dig[wr_addr] <= bad;
    end
  end

  // Scan state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= OFF;
      cnt    <= '0;
      dig    <= '0;
      codigo <= '0;
      anodo  <= '0;
      apaga  <= 1'b1;
      quadro <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      dig    <= dig_n;
      codigo <= codigo_n;
      anodo  <= anodo_n;
      apaga  <= apaga_n;
      quadro <= quadro_n;
    end
  end

  // Next-state logic; a digit is latched from the bank as it starts lighting
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    dig_n    = dig;
    codigo_n = codigo;
    anodo_n  = anodo;
    apaga_n  = apaga;
    quadro_n = 1'b0;
    if (!en) begin
      state_n = OFF;
      cnt_n   = '0;
      dig_n   = '0;
      anodo_n = '0;
      apaga_n = 1'b1;
    end else begin
      unique case (1'b1)
        state == OFF: begin
          cnt_n = '0;
          dig_n = '0;
          if (DEAD == 0) begin
            codigo_n = bank[0];
            apaga_n  = erro_dig[0];
            anodo_n  = N_DIG'(1);
            state_n  = SHOW;
          end else begin
            anodo_n = '0;
            apaga_n = 1'b1;
            state_n = GUARD;
          end
        end
        state == GUARD: begin
          if (cnt == DEAD_L) begin
            cnt_n    = '0;
            codigo_n = bank[dig];
            apaga_n  = erro_dig[dig];
            anodo_n  = N_DIG'(1) << dig;
            state_n  = SHOW;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        state == SHOW: begin
          if (cnt == DIV_L) begin
            cnt_n    = '0;
            dig_n    = nxt;
            quadro_n = (dig == LAST);
            if (DEAD == 0) begin
              codigo_n = bank[nxt];
              apaga_n  = erro_dig[nxt];
              anodo_n  = N_DIG'(1) << nxt;
            end else begin
              anodo_n = '0;
              apaga_n = 1'b1;
              state_n = GUARD;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          state_n = OFF;
          cnt_n   = '0;
          dig_n   = '0;
          anodo_n = '0;
          apaga_n = 1'b1;
        end
      endcase
    end
  end

endmodule
